// File: rtl/veda_mem_burst_master.sv
// veda_mem_burst_master: turns write/read burst commands into per-cycle accesses
// on the 32x32 veda memory port. Write words come in on a valid/ready stream.
// Read words go out through a 2-entry buffer on a valid/ready stream.
module veda_mem_burst_master #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              busy,
  output logic              mem_mode,
  output logic              mem_write_enab,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        occ_q, occ_d;
  logic [DATA_W-1:0] buf0_q, buf0_d;
  logic [DATA_W-1:0] buf1_q, buf1_d;
  logic              rd_pop;
  logic              rd_push;
  logic [1:0]        load;

  // Buffer head is always entry 0; a read issued last cycle returns its word now.
  assign rd_valid = (occ_q != 2'd0);
  assign rd_data  = buf0_q;
  assign rd_pop   = rd_valid & rd_ready;
  assign rd_push  = inflight_q;
  // Words that will occupy the buffer at the end of this cycle, excluding any new issue.
  assign load     = occ_q + {1'b0, inflight_q} - {1'b0, rd_pop};

  // State, pointer, counter and buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
      occ_q      <= 2'd0;
      buf0_q     <= '0;
      buf1_q     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
    end
  end

  // Next state and memory-side outputs; mem_mode drops to 0 only on an accepted write beat.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    rem_d          = rem_q;
    inflight_d     = 1'b0;
    cmd_ready      = 1'b0;
    wr_ready       = 1'b0;
    done           = 1'b0;
    busy           = 1'b1;
    mem_mode       = 1'b1;
    mem_write_enab = 1'b0;
    mem_address    = '0;
    mem_data_in    = '0;
    case (state_q)
      S_IDLE: begin
        busy      = 1'b0;
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_len == '0) begin
            state_d = S_DONE;
          end else if (cmd_write) begin
            ptr_d   = cmd_addr;
            rem_d   = cmd_len;
            state_d = S_WRITE;
          end else begin
            // First read issues in the accept cycle so data is buffered two cycles later.
            mem_address = cmd_addr;
            inflight_d  = 1'b1;
            ptr_d       = cmd_addr + 1'b1;
            rem_d       = cmd_len - 1'b1;
            state_d     = (cmd_len == LEN_W'(1)) ? S_DRAIN : S_READ;
          end
        end
      end
      S_WRITE: begin
        wr_ready    = 1'b1;
        mem_address = ptr_q;
        if (wr_valid) begin
          mem_mode       = 1'b0;
          mem_write_enab = 1'b1;
          mem_data_in    = wr_data;
          ptr_d          = ptr_q + 1'b1;
          rem_d          = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) state_d = S_DONE;
        end
      end
      S_READ: begin
        mem_address = ptr_q;
        if (load < 2'd2) begin
          inflight_d = 1'b1;
          ptr_d      = ptr_q + 1'b1;
          rem_d      = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!inflight_q && (occ_q == 2'd0)) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Two-entry read buffer; push and pop may coincide.
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    occ_d  = occ_q;
    case ({rd_push, rd_pop})
      2'b10: begin
        if (occ_q == 2'd0) buf0_d = mem_data_out;
        else               buf1_d = mem_data_out;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = mem_data_out;
        end else begin
          buf0_d = buf1_q;
          buf1_d = mem_data_out;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_veda_mem_burst_master.sv
// Directed bench for veda_mem_burst_master with a behavioural 32x32 memory and
// write/read scoreboards.
module tb_veda_mem_burst_master;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              wr_valid, wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid, rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              done, busy;
  logic              mem_mode, mem_write_enab;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in, mem_data_out;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  logic [DATA_W-1:0] mem    [0:31];
  logic [DATA_W-1:0] shadow [0:31];
  wr_t               wq[$];
  logic [DATA_W-1:0] rq[$];
  int                passed = 0;
  int                failed = 0;
  bit                mon_en = 1'b0;
  bit                prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data;

  always #5 clk = ~clk;

  veda_mem_burst_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done), .busy(busy),
    .mem_mode(mem_mode), .mem_write_enab(mem_write_enab),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out)
  );

  // Memory model: writes on every edge with mode 0, otherwise registers a read.
  always @(posedge clk) begin
    if (mem_mode === 1'b0) mem[mem_address] <= mem_data_in;
    else                   mem_data_out <= mem[mem_address];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor: every memory write and every read pop is matched against the scoreboards.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("we_mirrors_mode", mem_write_enab, !mem_mode);
      if (mem_mode === 1'b0) begin
        chk("write_expected", wq.size() != 0, 1);
        chk("write_on_handshake", wr_valid && wr_ready, 1);
        if (wq.size() != 0) begin
          wr_t e;
          e = wq.pop_front();
          chk("mem_wr_addr", mem_address, e.a);
          chk("mem_wr_data", mem_data_in, e.d);
        end
      end
      if (rd_valid && rd_ready) begin
        chk("read_expected", rq.size() != 0, 1);
        if (rq.size() != 0) chk("rd_data", rd_data, rq.pop_front());
      end
      if (prev_stall) begin
        chk("rd_hold_valid", rd_valid, 1);
        chk("rd_hold_data", rd_data, prev_data);
      end
      prev_stall = rd_valid && !rd_ready && !rst;
      prev_data  = rd_data;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Presents a command for one cycle; returns one cycle after the accept edge.
  task automatic send_cmd(input bit w, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] n);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = n;
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1);
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic write_burst(input logic [ADDR_W-1:0] a, input int unsigned n,
                             input logic [DATA_W-1:0] base, input bit gap);
    logic [ADDR_W-1:0] p;
    logic [DATA_W-1:0] d;
    p = a;
    wr_valid = 1'b0;
    send_cmd(1'b1, a, LEN_W'(n));
    for (int unsigned i = 0; i < n; i++) begin
      if (gap && i == 1) begin
        wr_valid = 1'b0;
        @(negedge clk);
        chk("gap_mode", mem_mode, 1);
        chk("gap_wr_ready", wr_ready, 1);
        cyc();
      end
      d = base + i;
      wr_valid = 1'b1;
      wr_data  = d;
      wq.push_back({p, d});
      shadow[p] = d;
      @(negedge clk);
      chk("wr_ready", wr_ready, 1);
      chk("wr_beat_addr", mem_address, p);
      cyc();
      p = p + 1'b1;
    end
    wr_valid = 1'b0;
    @(negedge clk);
    chk("wr_done", done, 1);
    chk("wr_done_busy", busy, 1);
    cyc();
    @(negedge clk);
    chk("wr_after_done", done, 0);
    chk("wr_idle_busy", busy, 0);
    cyc();
  endtask

  task automatic read_burst(input logic [ADDR_W-1:0] a, input int unsigned n, input bit toggle);
    logic [ADDR_W-1:0] p;
    bit seen;
    p = a;
    for (int unsigned i = 0; i < n; i++) begin
      rq.push_back(shadow[p]);
      p = p + 1'b1;
    end
    rd_ready = 1'b1;
    send_cmd(1'b0, a, LEN_W'(n));
    @(negedge clk);
    chk("rd_latency_c1", rd_valid, 0);
    if (!toggle) begin
      for (int unsigned i = 0; i < n; i++) begin
        cyc();
        @(negedge clk);
        chk("rd_stream_valid", rd_valid, 1);
      end
    end
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      cyc();
      if (toggle) rd_ready = !rd_ready;
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("rd_done_seen", seen, 1);
    chk("rd_all_delivered", rq.size(), 0);
    cyc();
    rd_ready = 1'b0;
    @(negedge clk);
    chk("rd_after_done", done, 0);
    chk("rd_idle_busy", busy, 0);
    cyc();
  endtask

  task automatic zero_len(input bit w, input logic [ADDR_W-1:0] a);
    send_cmd(w, a, '0);
    @(negedge clk);
    chk("len0_done", done, 1);
    chk("len0_mode", mem_mode, 1);
    cyc();
    @(negedge clk);
    chk("len0_after", done, 0);
    chk("len0_idle", cmd_ready, 1);
    cyc();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      mem[i]    = '0;
      shadow[i] = '0;
    end

    // Reset for two cycles.
    cyc();
    @(negedge clk);
    chk("rst_mode_c1", mem_mode, 1);
    cyc();
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mode", mem_mode, 1);
    chk("rst_we", mem_write_enab, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_din", mem_data_in, 0);
    cyc();
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", cmd_ready, 1);
    cyc();

    write_burst(5'd3, 4, 32'hA000_00A0, 1'b0);
    read_burst(5'd3, 4, 1'b0);

    write_burst(5'd30, 4, 32'hB000_00B0, 1'b0);
    read_burst(5'd30, 4, 1'b0);

    write_burst(5'd7, 6, 32'hC000_00C0, 1'b1);
    read_burst(5'd3, 8, 1'b1);

    zero_len(1'b1, 5'd9);
    zero_len(1'b0, 5'd9);

    write_burst(5'd0, 34, 32'hD000_00D0, 1'b0);
    read_burst(5'd0, 34, 1'b1);

    // Stalled read, ignored command while busy, then reset mid-burst.
    rd_ready = 1'b0;
    send_cmd(1'b0, 5'd3, 6'd8);
    cyc();
    cyc();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'd12; cmd_len = 6'd2;
    @(negedge clk);
    chk("busy_cmd_ready", cmd_ready, 0);
    chk("stalled_rd_valid", rd_valid, 1);
    cyc();
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("cmd_ignored_busy", busy, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_rd_valid", rd_valid, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    chk("midrst_done", done, 0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      @(negedge clk);
      chk("midrst_no_done", done, 0);
    end

    chk("no_pending_writes", wq.size(), 0);
    chk("no_pending_reads", rq.size(), 0);
    $display("%0d/%0d checks passed", passed, passed + failed);
    $finish;
  end

endmodule
